icache_responder: RTL and testbench

- Responder end of the fetch-side i-cache address/data handshake. Accepts line-read requests on the addr channel and returns whole cache lines on the data channel as icache_out_t.
- Backed by an internal line-wide memory array, preloaded through a write port. Fixed-latency read pipeline feeds a credit-limited response FIFO.
- Serves as the i-cache model for fetch-stage integration and as the SRAM front end of the future i-cache.

---
 rtl/icache_responder.sv | 98 +++++++++
 tb/tb_icache_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// icache_responder: line-read responder with preloadable backing array, fixed-latency pipeline and credit-limited response FIFO
package icache_pkg;
  localparam int XLEN = 32;
  localparam int LINE_BYTES = 16;
  localparam int LINE_W = 8 * LINE_BYTES;
  typedef struct packed {
    logic [LINE_W-1:0] line;
    logic [XLEN-1:0]   addr;
  } icache_out_t;
endpackage

module icache_responder #(
  parameter int LINE_BYTES = icache_pkg::LINE_BYTES,
  parameter int N_LINES    = 256,
  parameter int LATENCY    = 2,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic [icache_pkg::XLEN-1:0]   addr_i,
  input  logic                          addr_valid_i,
  output logic                          addr_ready_o,
  output icache_pkg::icache_out_t       data_o,
  output logic                          data_valid_o,
  input  logic                          data_ready_i,
  input  logic                          wr_en_i,
  input  logic [$clog2(N_LINES)-1:0]    wr_idx_i,
  input  logic [8*LINE_BYTES-1:0]       wr_line_i
);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int OB = $clog2(LINE_BYTES);
  localparam int IB = $clog2(N_LINES);
  localparam int PW = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int NS = LATENCY - 1;
  logic [LINE_W-1:0] mem [N_LINES];
  icache_pkg::icache_out_t fifo [OUT_DEPTH];
  icache_pkg::icache_out_t in_d, push_d;
  logic [IB-1:0] idx;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] fcnt, cnt;
  logic accept, pop, push;
  assign idx = addr_i[OB +: IB];
  assign addr_ready_o = (cnt < CW'(OUT_DEPTH)) & ~flush_i & rst_n_i;
  assign accept = addr_valid_i & addr_ready_o;
  assign data_valid_o = fcnt != '0;
  assign pop = data_valid_o & data_ready_i;
  assign data_o = data_valid_o ? fifo[rp] : '0;
  // array read at acceptance; a same-edge preload write is not yet visible, so old data is returned
  always_comb begin
    in_d.line = mem[idx];
    in_d.addr = addr_i & ~icache_pkg::XLEN'(LINE_BYTES - 1);
  end
  // preload port; contents survive reset and flush
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_idx_i] <= wr_line_i;
  end
  generate
    if (LATENCY == 1) begin : g_direct
      assign push = accept;
      assign push_d = in_d;
    end else begin : g_pipe
      logic [NS-1:0] pv;
      icache_pkg::icache_out_t pd [NS];
      // valid-tagged delay stages; the FIFO write is the final stage
      always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) pv <= '0;
        else begin
          pv[0] <= accept;
          for (int k = 1; k < NS; k++) pv[k] <= pv[k-1];
        end
        pd[0] <= in_d;
        for (int k = 1; k < NS; k++) pd[k] <= pd[k-1];
      end
      assign push = pv[NS-1];
      assign push_d = pd[NS-1];
    end
  endgenerate
  // response FIFO payload; credits guarantee a free slot on every push
  always_ff @(posedge clk_i) begin
    if (push) fifo[wp] <= push_d;
  end
  // FIFO pointers, fill level and outstanding-request credits; flush outranks push, pop and accept
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      wp <= '0;
      rp <= '0;
      fcnt <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= (wp == PW'(OUT_DEPTH - 1)) ? '0 : wp + 1'b1;
      if (pop) rp <= (rp == PW'(OUT_DEPTH - 1)) ? '0 : rp + 1'b1;
      fcnt <= fcnt + CW'(push) - CW'(pop);
      cnt <= cnt + CW'(accept) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed scoreboard bench for icache_responder
module tb_icache_responder;
  logic clk_i = 0, rst_n_i, flush_i, addr_valid_i, data_ready_i, wr_en_i;
  logic [31:0] addr_i;
  logic addr_ready_o, data_valid_o;
  icache_pkg::icache_out_t data_o;
  logic [7:0] wr_idx_i;
  logic [127:0] wr_line_i;
  typedef struct { logic [127:0] line; logic [31:0] addr; } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [127:0] ref_mem [256];
  int checks = 0, errors = 0, pop_cnt = 0, p0, acc;
  localparam logic [127:0] L3 = 128'h0F0E0D0C_0B0A0908_07060504_DDCCBBAA;
  localparam logic [127:0] NEW5 = 128'hFEEDFACE_CAFEBABE_DEADBEEF_01234567;

  icache_responder dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .addr_i(addr_i),
    .addr_valid_i(addr_valid_i), .addr_ready_o(addr_ready_o), .data_o(data_o),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .wr_en_i(wr_en_i),
    .wr_idx_i(wr_idx_i), .wr_line_i(wr_line_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] pat(int i);
    return i == 3 ? L3 : {4{32'hC0DE0000 + 32'(i)}};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
    #1;
  endtask

  // scoreboard: push expectation on accept (reading the model before this cycle's write), pop and compare on handshake
  always @(negedge clk_i) begin
    if (!rst_n_i) sb.delete();
    else begin
      if (data_valid_o && data_ready_i) begin
        pop_cnt++;
        chk("sb_has_entry", 160'(sb.size() != 0), 160'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("resp_line", 160'(data_o.line), 160'(e.line));
          chk("resp_addr", 160'(data_o.addr), 160'(e.addr));
        end
      end
      if (flush_i) sb.delete();
      else if (addr_valid_i && addr_ready_o)
        sb.push_back('{line: ref_mem[addr_i[11:4]], addr: addr_i & ~32'hF});
    end
    if (wr_en_i) ref_mem[wr_idx_i] = wr_line_i;
  end

  initial begin
    rst_n_i = 0; flush_i = 0; addr_i = 0; addr_valid_i = 0; data_ready_i = 1;
    wr_en_i = 0; wr_idx_i = 0; wr_line_i = 0;
    tick(); tick();
    mid();
    chk("rst_ready", 160'(addr_ready_o), 160'(0));
    chk("rst_valid", 160'(data_valid_o), 160'(0));
    chk("rst_data", 160'(data_o), 160'(0));
    tick();
    rst_n_i = 1;
    mid();
    chk("rst_ready_after", 160'(addr_ready_o), 160'(1));
    tick();
    for (int i = 0; i < 8; i++) begin
      wr_en_i = 1; wr_idx_i = 8'(i); wr_line_i = pat(i);
      tick();
    end
    wr_en_i = 0;
    // single read
    addr_i = 32'h34; addr_valid_i = 1;
    mid();
    chk("single_accept", 160'(addr_ready_o), 160'(1));
    tick();
    addr_valid_i = 0;
    mid();
    chk("single_t1_valid", 160'(data_valid_o), 160'(0));
    tick(); mid();
    chk("single_t2_valid", 160'(data_valid_o), 160'(1));
    chk("single_t2_line", 160'(data_o.line), 160'(L3));
    chk("single_t2_addr", 160'(data_o.addr), 160'(32'h30));
    tick(); mid();
    chk("single_t3_valid", 160'(data_valid_o), 160'(0));
    // streaming
    tick();
    p0 = pop_cnt; acc = 0;
    for (int i = 0; i < 8; i++) begin
      addr_i = 32'(i * 16); addr_valid_i = 1;
      mid();
      acc += int'(addr_ready_o);
      tick();
    end
    addr_valid_i = 0;
    chk("stream_ready", 160'(acc), 160'(8));
    mid();
    chk("stream_pops_7", 160'(pop_cnt - p0), 160'(7));
    tick(); mid();
    chk("stream_pops_8", 160'(pop_cnt - p0), 160'(8));
    tick(); mid();
    chk("stream_idle", 160'(data_valid_o), 160'(0));
    // back-pressure
    tick();
    data_ready_i = 0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      addr_i = 32'(i * 16); addr_valid_i = 1;
      mid();
      acc += int'(addr_ready_o);
      tick();
    end
    addr_valid_i = 0;
    mid();
    chk("bp_accepts", 160'(acc), 160'(4));
    chk("bp_ready_full", 160'(addr_ready_o), 160'(0));
    chk("bp_valid", 160'(data_valid_o), 160'(1));
    chk("bp_head_line", 160'(data_o.line), 160'(pat(0)));
    tick(); tick(); mid();
    chk("bp_hold_line", 160'(data_o.line), 160'(pat(0)));
    chk("bp_hold_addr", 160'(data_o.addr), 160'(0));
    tick();
    data_ready_i = 1; p0 = pop_cnt;
    mid();
    chk("bp_ready_pop0", 160'(addr_ready_o), 160'(0));
    tick(); mid();
    chk("bp_ready_return", 160'(addr_ready_o), 160'(1));
    tick(); tick(); mid();
    chk("bp_pops", 160'(pop_cnt - p0), 160'(4));
    tick(); mid();
    chk("bp_drained", 160'(data_valid_o), 160'(0));
    // flush mid-flight
    tick();
    data_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      addr_i = 32'h40 + 32'(i * 16); addr_valid_i = 1;
      tick();
    end
    addr_valid_i = 0; flush_i = 1;
    mid();
    chk("fl_ready", 160'(addr_ready_o), 160'(0));
    chk("fl_valid_before", 160'(data_valid_o), 160'(1));
    tick();
    flush_i = 0; data_ready_i = 1; addr_i = 32'h20; addr_valid_i = 1; p0 = pop_cnt;
    mid();
    chk("fl_valid_after", 160'(data_valid_o), 160'(0));
    chk("fl_accept", 160'(addr_ready_o), 160'(1));
    tick();
    addr_valid_i = 0;
    mid();
    chk("fl_t1_valid", 160'(data_valid_o), 160'(0));
    tick(); mid();
    chk("fl_t2_valid", 160'(data_valid_o), 160'(1));
    chk("fl_t2_addr", 160'(data_o.addr), 160'(32'h20));
    tick(); mid();
    chk("fl_pops", 160'(pop_cnt - p0), 160'(1));
    tick();
    data_ready_i = 0; acc = 0;
    for (int i = 0; i < 5; i++) begin
      addr_i = 32'(i * 16); addr_valid_i = 1;
      mid();
      acc += int'(addr_ready_o);
      tick();
    end
    addr_valid_i = 0;
    chk("fl_credits", 160'(acc), 160'(4));
    data_ready_i = 1;
    for (int i = 0; i < 6; i++) tick();
    mid();
    chk("fl_drained", 160'(data_valid_o), 160'(0));
    // wrap and read-during-write
    tick();
    p0 = pop_cnt;
    addr_i = 32'h1000; addr_valid_i = 1;
    tick();
    addr_i = 32'h50; wr_en_i = 1; wr_idx_i = 8'd5; wr_line_i = NEW5;
    tick();
    wr_en_i = 0;
    mid();
    chk("wrap_line", 160'(data_o.line), 160'(pat(0)));
    chk("wrap_addr", 160'(data_o.addr), 160'(32'h1000));
    tick();
    addr_valid_i = 0;
    mid();
    chk("rdw_old_line", 160'(data_o.line), 160'(pat(5)));
    tick(); mid();
    chk("rdw_new_line", 160'(data_o.line), 160'(NEW5));
    tick(); mid();
    chk("rdw_pops", 160'(pop_cnt - p0), 160'(3));
    // reset with a full FIFO
    tick();
    data_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      addr_i = 32'(i * 16); addr_valid_i = 1;
      tick();
    end
    addr_valid_i = 0;
    tick(); tick();
    rst_n_i = 0;
    mid();
    chk("rs_valid_full", 160'(data_valid_o), 160'(1));
    chk("rs_ready_in_reset", 160'(addr_ready_o), 160'(0));
    tick();
    rst_n_i = 1; data_ready_i = 1; p0 = pop_cnt;
    mid();
    chk("rs_valid_after", 160'(data_valid_o), 160'(0));
    chk("rs_ready_after", 160'(addr_ready_o), 160'(1));
    chk("rs_data_after", 160'(data_o), 160'(0));
    tick(); tick(); tick(); mid();
    chk("rs_no_stale", 160'(pop_cnt - p0), 160'(0));
    chk("sb_empty_end", 160'(sb.size()), 160'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
